// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter between a command-response
// requester (0) and a telemetry requester (1), sending 1- or 2-byte packets high byte first.
module uart_tx_sched #(
   parameter int GAP_CYC = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        len0,
   input  logic [15:0] data0,
   output logic        ack0,
   output logic        done0,
   input  logic        req1,
   input  logic        len1,
   input  logic [15:0] data1,
   output logic        ack1,
   output logic        done1,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        gnt_id
);

   typedef enum logic [2:0] {
      IDLE,
      SEND_HI,
      WAIT_HI,
      GAP,
      SEND_LO,
      WAIT_LO,
      FIN
   } state_t;

   localparam logic [11:0] GAP_LIM = 12'(GAP_CYC);

   state_t      state_reg;
   logic [1:0]  ack_reg;
   logic [1:0]  done_reg;
   logic        trmt_reg;
   logic [7:0]  tx_data_reg;
   logic        busy_reg;
   logic        gnt_reg;
   logic        last_gnt_reg;
   logic [15:0] pay_reg;
   logic [11:0] gap_cnt_reg;

   logic        any_req;
   logic        pick;
   logic        pick_len;
   logic [15:0] pick_data;

   // On a tie the requester that did not win last time gets the transmitter.
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         pick = ~last_gnt_reg;
      end else begin
         pick = req1 & ~req0;
      end
      pick_len  = pick ? len1 : len0;
      pick_data = pick ? data1 : data0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ack_reg      <= 2'b00;
         done_reg     <= 2'b00;
         trmt_reg     <= 1'b0;
         tx_data_reg  <= 8'h00;
         busy_reg     <= 1'b0;
         gnt_reg      <= 1'b0;
         last_gnt_reg <= 1'b1;
         pay_reg      <= 16'h0000;
         gap_cnt_reg  <= 12'd0;
      end else begin
         ack_reg  <= 2'b00;
         done_reg <= 2'b00;
         trmt_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               busy_reg <= 1'b0;
               if (any_req) begin
                  ack_reg      <= pick ? 2'b10 : 2'b01;
                  pay_reg      <= pick_data;
                  gnt_reg      <= pick;
                  last_gnt_reg <= pick;
                  busy_reg     <= 1'b1;
                  state_reg    <= pick_len ? SEND_HI : SEND_LO;
               end
            end
            SEND_HI: begin
               trmt_reg    <= 1'b1;
               tx_data_reg <= pay_reg[15:8];
               state_reg   <= WAIT_HI;
            end
            // tx_done is still stale while trmt is high; the transmitter clears it on that edge.
            WAIT_HI: begin
               if (!trmt_reg && tx_done) begin
                  gap_cnt_reg <= 12'd0;
                  state_reg   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt_reg == GAP_LIM) begin
                  state_reg <= SEND_LO;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 12'd1;
               end
            end
            SEND_LO: begin
               trmt_reg    <= 1'b1;
               tx_data_reg <= pay_reg[7:0];
               state_reg   <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!trmt_reg && tx_done) begin
                  done_reg  <= gnt_reg ? 2'b10 : 2'b01;
                  state_reg <= FIN;
               end
            end
            FIN: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ack0    = ack_reg[0];
   assign ack1    = ack_reg[1];
   assign done0   = done_reg[0];
   assign done1   = done_reg[1];
   assign trmt    = trmt_reg;
   assign tx_data = tx_data_reg;
   assign busy    = busy_reg;
   assign gnt_id  = gnt_reg;

endmodule
